// File: rtl/mips_bus_pkg.sv
// Shared types, constants and helpers for the MIPS Avalon bus master.
// Optional macro MIPS_BUS_ENDIAN_SWAP_EN is consumed by mips_bus_master.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeWordAlt = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam logic [3:0] BeByte   = 4'b0001;
    localparam logic [3:0] BeHalfLo = 4'b0011;
    localparam logic [3:0] BeHalfHi = 4'b1100;
    localparam logic [3:0] BeWord   = 4'b1111;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SizeByte: mis = 1'b0;
            SizeHalf: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SizeByte: be = BeByte << off;
            SizeHalf: be = off[1] ? BeHalfHi : BeHalfLo;
            default:  be = BeWord;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SizeByte: rep = {4{data[7:0]}};
            SizeHalf: rep = {2{data[15:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] data);
        return {data[7:0], data[15:8], data[23:16], data[31:24]};
    endfunction

endpackage

// File: rtl/mips_load_extend.sv
// Combinational load lane shift followed by zero or sign extension.
module mips_load_extend
    import mips_bus_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = data_i >> {offset_i, 3'b000};
        case (size_i)
            SizeByte: data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            SizeHalf: data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            default:  data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mips_bus_master.sv
// Multi-port MIPS load/store arbiter driving a single Avalon-MM master port.
// Define MIPS_BUS_ENDIAN_SWAP_EN to byte-swap data and bit-reverse byteenable at the bus.
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PORTS-1:0]   req_valid,
    output logic [N_PORTS-1:0]   req_ready,
    input  logic [N_PORTS-1:0]   req_write,
    input  logic [N_PORTS-1:0]   req_signed,
    input  logic [2*N_PORTS-1:0] req_size,
    input  logic [32*N_PORTS-1:0] req_addr,
    input  logic [32*N_PORTS-1:0] req_wdata,
    output logic [N_PORTS-1:0]   resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 busy,
    output logic [31:0]          address,
    output logic                 read,
    output logic                 write,
    input  logic                 waitrequest,
    output logic [31:0]          writedata,
    output logic [3:0]           byteenable,
    input  logic [31:0]          readdata
);

    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     port_q, port_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              is_wr_q, is_wr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       address_q, address_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [31:0]       sel_addr, sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_write, sel_signed;
    logic [31:0]       rdata_core, ext_data;

    // Fixed priority: lowest index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (req_valid[i] && !grant_found) begin
                grant_found = 1'b1;
                grant_idx   = PW'(i);
            end
        end
    end

    assign sel_addr   = req_addr[32*grant_idx +: 32];
    assign sel_wdata  = req_wdata[32*grant_idx +: 32];
    assign sel_size   = req_size[2*grant_idx +: 2];
    assign sel_write  = req_write[grant_idx];
    assign sel_signed = req_signed[grant_idx];

`ifdef MIPS_BUS_ENDIAN_SWAP_EN
    assign writedata  = bswap32(wdata_q);
    assign byteenable = {be_q[0], be_q[1], be_q[2], be_q[3]};
    assign rdata_core = bswap32(readdata);
`else
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign rdata_core = readdata;
`endif

    mips_load_extend u_load_extend (
        .data_i   (rdata_core),
        .offset_i (off_q),
        .size_i   (size_q),
        .sign_i   (signed_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        is_wr_d      = is_wr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        address_d    = address_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (grant_found) begin
                    port_d   = grant_idx;
                    off_d    = sel_addr[1:0];
                    size_d   = sel_size;
                    signed_d = sel_signed;
                    is_wr_d  = sel_write;
                    if (is_misaligned(sel_size, sel_addr[1:0])) begin
                        state_d      = StResp;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d   = StBus;
                        address_d = {sel_addr[31:2], 2'b00};
                        rd_d      = !sel_write;
                        wr_d      = sel_write;
                        be_d      = byte_enable(sel_size, sel_addr[1:0]);
                        wdata_d   = replicate(sel_size, sel_wdata);
                    end
                end
            end
            StBus: begin
                if (!waitrequest) begin
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    state_d      = StResp;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = is_wr_q ? 32'd0 : ext_data;
                end else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    state_d      = StResp;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StResp: begin
                state_d    = StIdle;
                wait_cnt_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            port_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            is_wr_q      <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            address_q    <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            is_wr_q      <= is_wr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            address_q    <= address_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Grant is combinational so the acceptance edge is the one that latches the request.
    assign req_ready  = (state_q == StIdle && grant_found && !reset) ?
                        (N_PORTS'(1) << grant_idx) : '0;
    assign resp_valid = (state_q == StResp) ? (N_PORTS'(1) << port_q) : '0;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != StIdle);
    assign address    = address_q;
    assign read       = rd_q;
    assign write      = wr_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Randomized self-checking bench for mips_bus_master against a transaction-level model.
module tb_mips_bus_master;

    localparam int NP   = 2;
    localparam int WMAX = 6;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid, req_ready, req_write, req_signed, resp_valid;
    logic [3:0]    req_size;
    logic [63:0]   req_addr, req_wdata;
    logic [31:0]   resp_rdata, address, writedata, readdata;
    logic          resp_err, busy, read, write, waitrequest;
    logic [3:0]    byteenable;

    int n_checks = 0;
    int n_pass   = 0;

    mips_bus_master #(
        .N_PORTS  (NP),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_signed  (req_signed),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .busy        (busy),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: one full request, from presenting it on a port to returning to idle.
    task automatic do_txn(input int port, input bit wr, input bit sg, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int nw);
        int          off, nb, bus_cycles;
        bit          mis, tout;
        logic [31:0] exp_be, exp_wd, exp_rd, v, lim;
        off = int'(addr[1:0]);
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = (nb == 2 && (off % 2) != 0) || (nb == 4 && off != 0);
        exp_be = ((32'd1 << nb) - 1) << off;
        exp_wd = (nb == 1) ? wd[7:0] * 32'h01010101 :
                 (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
        v = rd >> (8 * off);
        if (nb < 4) begin
            lim = 32'd1 << (8 * nb);
            v   = v % lim;
            if (sg && v >= lim / 2) v = v - lim;
        end
        exp_rd = wr ? 32'd0 : v;
        tout = (nw >= WMAX);
        bus_cycles = tout ? WMAX : nw + 1;

        req_valid[port]         = 1'b1;
        req_write[port]         = wr;
        req_signed[port]        = sg;
        req_size[2*port +: 2]   = sz;
        req_addr[32*port +: 32] = addr;
        req_wdata[32*port +: 32] = wd;
        readdata                = rd;
        waitrequest             = 1'b1;
        #1;
        check_eq("grant", {30'd0, req_ready}, 32'd1 << port);
        @(negedge clk);
        req_valid[port] = 1'b0;

        if (!mis) begin
            for (int k = 0; k < bus_cycles; k++) begin
                waitrequest = (k < nw);
                check_eq("bus_read", {31'd0, read}, {31'd0, !wr});
                check_eq("bus_write", {31'd0, write}, {31'd0, wr});
                check_eq("bus_addr", address, {addr[31:2], 2'b00});
                check_eq("bus_be", {28'd0, byteenable}, exp_be);
                if (wr) check_eq("bus_wdata", writedata, exp_wd);
                check_eq("bus_no_resp", {30'd0, resp_valid}, 32'd0);
                check_eq("bus_no_grant", {30'd0, req_ready}, 32'd0);
                @(negedge clk);
            end
        end
        check_eq("resp_valid", {30'd0, resp_valid}, 32'd1 << port);
        check_eq("resp_err", {31'd0, resp_err}, {31'd0, mis || tout});
        if (!mis && !tout) check_eq("resp_rdata", resp_rdata, exp_rd);
        check_eq("resp_rw_low", {30'd0, read, write}, 32'd0);
        check_eq("resp_no_grant", {30'd0, req_ready}, 32'd0);
        waitrequest = 1'b1;
        @(negedge clk);
        check_eq("idle_resp_low", {30'd0, resp_valid}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_signed  = '0;
        req_size    = '0;
        req_addr    = '0;
        req_wdata   = '0;
        readdata    = '0;
        waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_rw", {30'd0, read, write}, 32'd0);
        check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rst_resp", {29'd0, resp_valid, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_addr", address, 32'd0);
        check_eq("rst_wdata", writedata, 32'd0);
        check_eq("rst_be", {28'd0, byteenable}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed scenarios
        do_txn(0, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_txn(1, 1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        do_txn(1, 1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        do_txn(0, 1'b1, 1'b0, 2'b01, 32'h202, 32'h1234, 32'h0, 3);
        do_txn(0, 1'b0, 1'b0, 2'b10, 32'h101, 32'h0, 32'h0, 0);
        do_txn(0, 1'b0, 1'b0, 2'b10, 32'h40, 32'h0, 32'h0, WMAX + 4);
        do_txn(1, 1'b0, 1'b1, 2'b01, 32'h306, 32'h0, 32'h8001_7FFF, 1);

        // Both ports requesting: port 1 holds while port 0 is served.
        req_valid[1]    = 1'b1;
        req_write[1]    = 1'b0;
        req_signed[1]   = 1'b0;
        req_size[3:2]   = 2'b10;
        req_addr[63:32] = 32'h300;
        do_txn(0, 1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 32'h11223344, 1);
        do_txn(1, 1'b0, 1'b0, 2'b10, 32'h300, 32'h0, 32'h55667788, 0);

        // Reset while stalled in BUS.
        req_valid[0]   = 1'b1;
        req_write[0]   = 1'b0;
        req_size[1:0]  = 2'b10;
        req_addr[31:0] = 32'h500;
        waitrequest    = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("abort_read_before", {31'd0, read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_read", {31'd0, read}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_resp", {30'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_resp", {30'd0, resp_valid}, 32'd0);
        end
        waitrequest = 1'b1;

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int nw;
            nw = ($urandom_range(0, 7) == 0) ? WMAX + 1 : int'($urandom_range(0, 3));
            do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom, nw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_master.md
MIPS_BUS_MASTER -- requirements
Module: mips_bus_master

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesters (1..4; port 0 = fetch, highest priority).
REQ-002 SHALL have parameter WAIT_MAX, default 255, max consecutive waitrequest cycles before timeout.
REQ-003 SHALL have clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have req_valid  input  N_PORTS  per-port request strobe.
REQ-006 SHALL have req_ready  output  N_PORTS  one-hot grant, request accepted this cycle.
REQ-007 SHALL have req_write, req_signed  input  N_PORTS each  store select; sign-extend loads.
REQ-008 SHALL have req_size  input  2*N_PORTS  per port 00 byte, 01 half, 10 word (11 is treated as word).
REQ-009 SHALL have req_addr, req_wdata  input  32*N_PORTS each  byte address; store data in low bits.
REQ-010 SHALL have resp_valid  output  N_PORTS  one-cycle completion pulse to the granted port.
REQ-011 SHALL have resp_rdata  output  32  extended load data; resp_err  output  1  misaligned or timeout.
REQ-012 SHALL have busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have Avalon master: address out 32, read out 1, write out 1, waitrequest in 1, writedata out 32, byteenable out 4, readdata in 32.

Function
REQ-014 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; misaligned requests go IDLE -> RESP directly.
REQ-015 SHALL in IDLE grant the lowest-index valid port: req_ready pulses one cycle and the request is latched.
REQ-016 SHALL detect misalignment (half with addr[0]=1, word with addr[1:0]!=0), issue no bus cycle, and set resp_err=1.
REQ-017 SHALL in BUS drive address={addr[31:2],2'b00}, and drive read or write plus byteenable and writedata stable until waitrequest=0.
REQ-018 SHALL set byteenable: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-019 SHALL replicate store data into all lanes (byte x4, half x2).
REQ-020 SHALL sample readdata in the BUS cycle where waitrequest=0, then leave BUS.
REQ-021 SHALL extract loads by shifting right 8*addr[1:0], then zero-extend, or sign-extend when req_signed=1; stores return resp_rdata=0.
REQ-022 SHALL count consecutive waitrequest cycles in BUS; on reaching WAIT_MAX it drops read/write, goes to RESP, and sets resp_err=1.
REQ-023 SHALL in RESP pulse resp_valid for exactly one cycle on the granted port only, with resp_rdata/resp_err valid that cycle.
REQ-024 SHALL give a minimum latency of grant -> resp_valid of 2 cycles for a zero-wait access, plus 1 cycle per waitrequest cycle.
REQ-025 SHALL never assert read and write together, and SHALL grant nothing outside IDLE; requesters hold req_* until req_ready.

Reset
REQ-026 SHALL on reset go to IDLE and clear read, write, req_ready, resp_valid, resp_err, resp_rdata, busy, address, writedata, byteenable and the wait counter to 0.
REQ-027 SHALL, when reset is asserted mid-BUS, drop read/write at that edge and produce no response for the aborted request.

Configuration
REQ-028 SHALL support macro MIPS_BUS_ENDIAN_SWAP_EN.
REQ-029 With the macro defined: byte-reverse writedata and readdata at the bus boundary and bit-reverse byteenable (big-endian core on a little-endian bus).
REQ-030 Without the macro: pass data and byteenable through with no swap.

Structure
REQ-031 SHALL place the size encodings, FSM state enum and byteenable constants in shared package mips_bus_pkg.
REQ-032 SHALL use one sub-module, mips_load_extend, a combinational lane-shift and sign/zero-extend block.

Verification
REQ-033 Word load at 0x100, zero waits, readdata=0xDEADBEEF -> byteenable=1111; resp_valid 2 cycles after grant; resp_rdata=0xDEADBEEF.
REQ-034 Signed LB at 0x103, readdata=0x80FFFFFF (no swap) -> byteenable=1000; resp_rdata=0xFFFFFF80; unsigned gives 0x00000080.
REQ-035 SH at 0x202, wdata=0x1234, 3 waitrequest cycles -> writedata=0x12341234, byteenable=1100, write held 4 cycles, resp_valid then.
REQ-036 Port0 and port1 requesting together -> port0 granted first; port1 granted in the IDLE after port0's RESP.
REQ-037 Word load at 0x101 -> no read asserted; resp_err=1 one cycle after grant. Waitrequest stuck high -> resp_err after WAIT_MAX cycles.
REQ-038 Reset asserted during BUS with waitrequest=1 -> read=0 next cycle; no resp_valid; busy=0.
